load_store_unit: RTL and testbench

//  Bridge between the CPU data port and the word-only data RAM (combinational read, posedge write).

---
 rtl/lsu_if.sv | 31 +++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// CPU request/response and data-RAM port bundle for the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    // CPU plus RAM side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store bridge to a word-only RAM: lane select, extension and
// read-modify-write for sub-word stores; responses registered one cycle later.
module load_store_unit #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic  i_clk,
    input  logic  i_rst,
    lsu_if.slave  io_lsu
);
    localparam int unsigned DW = 32;

    typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata;
    logic             r_rsp_err;
    logic [DW-1:0]    r_old;
    logic [DW-1:0]    r_wdata;
    logic [1:0]       r_off;
    logic             r_is_half;
    logic [DW-3:0]    r_waddr;

    logic             w_ready;
    logic             w_accept;
    logic             w_legal;
    logic             w_misalign;
    logic             w_err;
    logic [1:0]       w_off;
    logic [DW-1:0]    w_lane_word;
    logic [DW-1:0]    w_load_data;
    logic [DW-1:0]    w_merged;

    assign w_ready  = (r_state == IDLE) & ~i_rst;
    assign w_accept = io_lsu.req_valid & w_ready;

    // Request decode: legality, alignment, effective lane and extended load data
    always_comb begin
        w_legal     = 1'b0;
        w_off       = 2'b00;
        w_load_data = '0;
        case (io_lsu.req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~io_lsu.req_we;
            default:                w_legal = 1'b0;
        endcase
        w_misalign = ((io_lsu.req_funct3[1:0] == 2'b01) && io_lsu.req_addr[0]) ||
                     ((io_lsu.req_funct3 == 3'b010) && (io_lsu.req_addr[1:0] != 2'b00));
        w_err      = ~w_legal | (ERR_ON_MISALIGN & w_misalign);
        // Offset is size-aligned; identical to addr[1:0] whenever the access is aligned
        case (io_lsu.req_funct3[1:0])
            2'b00:   w_off = io_lsu.req_addr[1:0];
            2'b01:   w_off = {io_lsu.req_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
        w_lane_word = io_lsu.mem_rdata >> {w_off, 3'b000};
        case (io_lsu.req_funct3)
            3'b000:  w_load_data = {{24{w_lane_word[7]}}, w_lane_word[7:0]};
            3'b001:  w_load_data = {{16{w_lane_word[15]}}, w_lane_word[15:0]};
            3'b100:  w_load_data = {24'h0, w_lane_word[7:0]};
            3'b101:  w_load_data = {16'h0, w_lane_word[15:0]};
            default: w_load_data = io_lsu.mem_rdata;
        endcase
    end

    // Replace the captured byte/half lane in the old word
    always_comb begin
        w_merged = r_old;
        if (r_is_half) begin
            if (r_off[1]) w_merged[31:16] = r_wdata[15:0];
            else          w_merged[15:0]  = r_wdata[15:0];
        end else begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // Next state and combinational RAM/handshake outputs
    always_comb begin
        w_state_nxt       = r_state;
        io_lsu.req_ready  = w_ready;
        io_lsu.mem_addr   = {io_lsu.req_addr[31:2], 2'b00};
        io_lsu.mem_read   = 1'b0;
        io_lsu.mem_write  = 1'b0;
        io_lsu.mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_err) begin
                    if (!io_lsu.req_we) begin
                        io_lsu.mem_read = 1'b1;
                    end else if (io_lsu.req_funct3 == 3'b010) begin
                        io_lsu.mem_write = 1'b1;
                        io_lsu.mem_wdata = io_lsu.req_wdata;
                    end else begin
                        io_lsu.mem_read = 1'b1;
                        w_state_nxt     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                io_lsu.mem_addr  = {r_waddr, 2'b00};
                io_lsu.mem_write = 1'b1;
                io_lsu.mem_wdata = w_merged;
                w_state_nxt      = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_rst) begin
            io_lsu.mem_read  = 1'b0;
            io_lsu.mem_write = 1'b0;
            w_state_nxt      = IDLE;
        end
    end

    // State and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 1'b0;
            if (r_state == RMW_WR) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end else if (!io_lsu.req_we) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_load_data;
                    r_rsp_err   <= 1'b0;
                end else if (io_lsu.req_funct3 == 3'b010) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
            end
        end
    end

    // Merge registers captured on a sub-word store accept
    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && w_accept && !w_err && io_lsu.req_we &&
            io_lsu.req_funct3 != 3'b010) begin
            r_old     <= io_lsu.mem_rdata;
            r_wdata   <= io_lsu.req_wdata;
            r_off     <= w_off;
            r_is_half <= io_lsu.req_funct3[0];
            r_waddr   <= io_lsu.req_addr[31:2];
        end
    end

    assign io_lsu.rsp_valid = r_rsp_valid;
    assign io_lsu.rsp_rdata = r_rsp_rdata;
    assign io_lsu.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and reference-model checks for load_store_unit against a word RAM.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   wr_cnt;

    logic [31:0] ram [64];
    logic [7:0]  rb  [256];

    lsu_if bus();

    load_store_unit #(.ERR_ON_MISALIGN(1'b1)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_lsu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read, posedge-write word RAM
    assign bus.mem_rdata = bus.mem_read ? ram[bus.mem_addr[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_write) begin
            ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; called #1 after a posedge. Returns response and timing.
    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int busy);
        int stall;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        stall = 0;
        while (!bus.req_ready && stall < 8) begin
            @(posedge clk); #1;
            stall++;
        end
        if (stall >= 8) check("ready_timeout", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!bus.rsp_valid && lat < 5) begin
            if (!bus.req_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          busy;
    int          wc0;

    initial begin
        n_chk = 0; n_fail = 0; wr_cnt = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[16] = 32'h8899AABB;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h0;
        rst = 1'b1;

        // Reset state, with a request pending to show it is ignored
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mem_read",  32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Loads: lane select and extension
        xfer(1'b0, 3'b000, 32'h41, 32'h0, rd, er, lat, busy);
        check("lb_41", rd, 32'hFFFFFFAA);
        check("lb_41_lat", 32'(lat), 32'd1);
        xfer(1'b0, 3'b100, 32'h43, 32'h0, rd, er, lat, busy);
        check("lbu_43", rd, 32'h00000088);
        xfer(1'b0, 3'b101, 32'h42, 32'h0, rd, er, lat, busy);
        check("lhu_42", rd, 32'h00008899);
        xfer(1'b0, 3'b001, 32'h42, 32'h0, rd, er, lat, busy);
        check("lh_42", rd, 32'hFFFF8899);

        // Sub-word store: read-modify-write
        wc0 = wr_cnt;
        xfer(1'b1, 3'b000, 32'h42, 32'h55, rd, er, lat, busy);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_busy", 32'(busy), 32'd1);
        check("sb_err", 32'(er), 32'd0);
        check("sb_writes", 32'(wr_cnt - wc0), 32'd1);
        check("sb_ram", ram[16], 32'h8855AABB);

        // SW then LW back-to-back, no stall
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h44; bus.req_wdata = 32'hDEADBEEF;
        check("sw_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        check("sw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_we = 1'b0;
        check("lw_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("lw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("lw_rdata", bus.rsp_rdata, 32'hDEADBEEF);

        // Misaligned SH
        wc0 = wr_cnt;
        xfer(1'b1, 3'b001, 32'h41, 32'h1234, rd, er, lat, busy);
        check("sh_mis_err", 32'(er), 32'd1);
        check("sh_mis_rdata", rd, 32'h0);
        check("sh_mis_lat", 32'(lat), 32'd1);
        check("sh_mis_writes", 32'(wr_cnt - wc0), 32'd0);
        check("sh_mis_ram", ram[16], 32'h8855AABB);

        // Illegal funct3
        xfer(1'b0, 3'b011, 32'h40, 32'h0, rd, er, lat, busy);
        check("f3_3_err", 32'(er), 32'd1);
        check("f3_3_rdata", rd, 32'h0);
        xfer(1'b1, 3'b100, 32'h40, 32'h0, rd, er, lat, busy);
        check("sbu_err", 32'(er), 32'd1);

        // Reset during RMW_WR drops the write and the response
        wc0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h11;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rmw_mem_write", 32'(bus.mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rmw_rsp0", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_rmw_rsp1", 32'(bus.rsp_valid), 32'd0);
        check("rst_rmw_writes", 32'(wr_cnt - wc0), 32'd0);
        check("rst_rmw_ram", ram[16], 32'h8855AABB);

        // Mixed traffic against a byte-array reference
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'(i) * 32'h01030507 ^ 32'hA5C3_0F69;
            for (int b = 0; b < 4; b++) rb[i*4+b] = ram[i][b*8 +: 8];
        end
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp_rd, hw, wv;
            logic        exp_err, ill, mis;
            int          exp_lat;
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'b011;
            endcase
            a  = 32'h40 + 32'($urandom_range(0, 63));
            wd = $urandom;
            ill = (f3 == 3'b011) || (we && (f3 == 3'b100 || f3 == 3'b101));
            mis = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
            exp_err = ill || mis;
            exp_rd  = 32'h0;
            exp_lat = 1;
            hw = {16'h0, rb[a[7:0] + 8'd1], rb[a[7:0]]};
            wv = {rb[a[7:0] + 8'd3], rb[a[7:0] + 8'd2], rb[a[7:0] + 8'd1], rb[a[7:0]]};
            if (!exp_err && !we) begin
                case (f3)
                    3'b000:  exp_rd = {{24{rb[a[7:0]][7]}}, rb[a[7:0]]};
                    3'b100:  exp_rd = {24'h0, rb[a[7:0]]};
                    3'b001:  exp_rd = {{16{hw[15]}}, hw[15:0]};
                    3'b101:  exp_rd = hw;
                    default: exp_rd = wv;
                endcase
            end else if (!exp_err && we) begin
                rb[a[7:0]] = wd[7:0];
                if (f3 != 3'b000) rb[a[7:0] + 8'd1] = wd[15:8];
                if (f3 == 3'b010) begin
                    rb[a[7:0] + 8'd2] = wd[23:16];
                    rb[a[7:0] + 8'd3] = wd[31:24];
                end else begin
                    exp_lat = 2;
                end
            end
            xfer(we, f3, a, wd, rd, er, lat, busy);
            if (rd !== exp_rd || er !== exp_err || lat != exp_lat)
                $display("  op %0d we=%0d f3=%0d addr=0x%02h wdata=0x%08h", n, we, f3, a[7:0], wd);
            check("rand_rdata", rd, exp_rd);
            check("rand_err", 32'(er), 32'(exp_err));
            check("rand_lat", 32'(lat), 32'(exp_lat));
        end
        for (int i = 16; i < 32; i++)
            check("rand_ram", ram[i], {rb[i*4+3], rb[i*4+2], rb[i*4+1], rb[i*4]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
